sdram_toggle_responder: RTL and testbench

Responder end of the 16-bit toggle req/ack memory protocol driven by RV and other initiators. It detects a new request when `mem_req` differs from `mem_req_ack`, captures the request fields, and issues one command on the SDRAM controller's valid/ready command channel. It returns read data from the controller's response strobe, then completes the request by toggling `mem_req_ack`.

---
 rtl/sdram_toggle_responder.sv | 134 +++++++++++++
 tb/tb_sdram_toggle_responder.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/sdram_toggle_responder.sv
// rtl/sdram_toggle_responder.sv - toggle req/ack responder issuing single commands to an SDRAM controller
// Optional read watchdog: define SDRAM_RESP_TIMEOUT_EN (limit set by TIMEOUT).
module sdram_toggle_responder #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_req,
  input  logic [22:1] mem_addr,
  input  logic [1:0]  mem_ds,
  input  logic [15:0] mem_din,
  input  logic        mem_we,
  output logic        mem_req_ack,
  output logic [15:0] mem_dout,
  output logic        sd_cmd_valid,
  input  logic        sd_cmd_ready,
  output logic        sd_we,
  output logic [22:1] sd_addr,
  output logic [1:0]  sd_ds,
  output logic [15:0] sd_wdata,
  input  logic        sd_rdata_valid,
  input  logic [15:0] sd_rdata,
  output logic        err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RD, S_DONE} state_t;

  state_t      state_q;
  logic        ack_q;
  logic        cmd_valid_q;
  logic        we_q;
  logic [22:1] addr_q;
  logic [1:0]  ds_q;
  logic [15:0] wdata_q;
  logic [15:0] dout_q;

  if (TIMEOUT == 0 || TIMEOUT > 65535) begin : g_timeout_range
    $error("sdram_toggle_responder: TIMEOUT must be in 1..65535");
  end

`ifdef SDRAM_RESP_TIMEOUT_EN
  // Counter value on the WAIT_RD edge where it reaches TIMEOUT.
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);
  logic [15:0] wd_q;
  logic [15:0] wd_d;
  logic        err_q;
  assign wd_d = wd_q + 16'd1;
  assign err  = err_q;
`else
  assign err  = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      ack_q       <= 1'b0;
      cmd_valid_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      ds_q        <= 2'b00;
      wdata_q     <= 16'h0000;
      dout_q      <= 16'h0000;
`ifdef SDRAM_RESP_TIMEOUT_EN
      wd_q        <= 16'h0000;
      err_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (mem_req != ack_q) begin
            we_q    <= mem_we;
            addr_q  <= mem_addr;
            ds_q    <= mem_ds;
            wdata_q <= mem_din;
            // A write with no byte lanes enabled completes without touching the controller.
            if (mem_we && mem_ds == 2'b00) begin
              state_q <= S_DONE;
            end else begin
              cmd_valid_q <= 1'b1;
              state_q     <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (sd_cmd_ready) begin
            cmd_valid_q <= 1'b0;
            if (we_q) begin
              ack_q   <= ~ack_q;
              state_q <= S_DONE;
            end else begin
              state_q <= S_WAIT_RD;
`ifdef SDRAM_RESP_TIMEOUT_EN
              wd_q    <= 16'h0000;
`endif
            end
          end
        end
        S_WAIT_RD: begin
          if (sd_rdata_valid) begin
            dout_q  <= sd_rdata;
            ack_q   <= ~ack_q;
            state_q <= S_DONE;
          end
`ifdef SDRAM_RESP_TIMEOUT_EN
          else if (wd_q == WD_LAST) begin
            dout_q  <= 16'hDEAD;
            ack_q   <= ~ack_q;
            err_q   <= 1'b1;
            state_q <= S_DONE;
          end else begin
            wd_q <= wd_d;
          end
`endif
        end
        S_DONE: begin
          if (we_q && ds_q == 2'b00) begin
            ack_q <= ~ack_q;
          end
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_req_ack  = ack_q;
  assign mem_dout     = dout_q;
  assign sd_cmd_valid = cmd_valid_q;
  assign sd_we        = we_q;
  assign sd_addr      = addr_q;
  assign sd_ds        = ds_q;
  assign sd_wdata     = wdata_q;

endmodule

// File: tb/tb_sdram_toggle_responder.sv
// tb/tb_sdram_toggle_responder.sv - randomized self-checking bench for sdram_toggle_responder
// Timeout scenario runs only when SDRAM_RESP_TIMEOUT_EN is defined.
module tb_sdram_toggle_responder;

  localparam int unsigned TIMEOUT = 8;
  localparam int MAX_CYC = 400;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        mem_req = 1'b0;
  logic [22:1] mem_addr = '0;
  logic [1:0]  mem_ds = 2'b00;
  logic [15:0] mem_din = 16'h0000;
  logic        mem_we = 1'b0;
  logic        mem_req_ack;
  logic [15:0] mem_dout;
  logic        sd_cmd_valid;
  logic        sd_cmd_ready = 1'b0;
  logic        sd_we;
  logic [22:1] sd_addr;
  logic [1:0]  sd_ds;
  logic [15:0] sd_wdata;
  logic        sd_rdata_valid = 1'b0;
  logic [15:0] sd_rdata = 16'h0000;
  logic        err;

  sdram_toggle_responder #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .resetn(resetn),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ds(mem_ds), .mem_din(mem_din), .mem_we(mem_we),
    .mem_req_ack(mem_req_ack), .mem_dout(mem_dout),
    .sd_cmd_valid(sd_cmd_valid), .sd_cmd_ready(sd_cmd_ready),
    .sd_we(sd_we), .sd_addr(sd_addr), .sd_ds(sd_ds), .sd_wdata(sd_wdata),
    .sd_rdata_valid(sd_rdata_valid), .sd_rdata(sd_rdata), .err(err)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [15:0] model_dout = 16'h0000;
  logic        model_err = 1'b0;
  bit          prev_ds0 = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One initiator request against a controller that stalls rdy_dly cycles and answers
  // reads rd_lat cycles after acceptance (rd_lat < 0: never answers).
  task automatic run_txn(input bit b2b, input logic we, input logic [22:1] addr, input logic [1:0] ds,
                         input logic [15:0] din, input int rdy_dly, input int rd_lat, input logic [15:0] rdata);
    int cyc, vcyc, k, n_cmd, extra, c_acc, exp_cyc;
    bit issued, stable, late_valid, is_cmd;
    is_cmd = !(we && ds == 2'b00);
    // Back-to-back requests wait out the DONE bubble unless the last request finished in DONE already.
    extra = (b2b && !prev_ds0) ? 1 : 0;
    if (!b2b) @(negedge clk);
    mem_we = we; mem_addr = addr; mem_ds = ds; mem_din = din;
    mem_req = ~mem_req;
    cyc = 0; vcyc = 0; k = 0; n_cmd = 0; c_acc = 0;
    issued = 0; stable = 1; late_valid = 0;
    while (cyc < MAX_CYC) begin
      @(negedge clk);
      cyc++;
      sd_cmd_ready = 1'b0;
      sd_rdata_valid = 1'b0;
      sd_rdata = 16'($urandom);
      if (mem_req_ack == mem_req) break;
      if (cyc >= 1 + extra) begin
        mem_addr = 22'($urandom); mem_din = 16'($urandom); mem_ds = 2'($urandom); mem_we = 1'($urandom);
      end
      if (sd_cmd_valid && !issued) begin
        if (vcyc == 0) check("cmd_fields", {sd_we, sd_addr, sd_ds, sd_wdata}, {we, addr, ds, din});
        else if ({sd_we, sd_addr, sd_ds, sd_wdata} !== {we, addr, ds, din}) stable = 0;
        sd_cmd_ready = (vcyc >= rdy_dly);
        if (sd_cmd_ready) begin issued = 1; n_cmd++; c_acc = cyc; end
        vcyc++;
      end else begin
        if (sd_cmd_valid) late_valid = 1;
        sd_cmd_ready = 1'($urandom_range(0, 1));
        if (!issued) begin
          sd_rdata_valid = ($urandom_range(0, 2) == 0);
        end else if (!we) begin
          k++;
          if (rd_lat >= 0 && k == rd_lat + 1) begin
            sd_rdata_valid = 1'b1;
            sd_rdata = rdata;
          end
        end
      end
    end
    sd_cmd_ready = 1'b0;
    sd_rdata_valid = 1'b0;
    if (!is_cmd) exp_cyc = 2 + extra;
    else if (we) exp_cyc = 2 + extra + rdy_dly;
    else if (rd_lat >= 0) exp_cyc = 1 + extra + rdy_dly + rd_lat + 2;
    else exp_cyc = 1 + extra + rdy_dly + 1 + int'(TIMEOUT);
    if (!we) begin
      if (rd_lat >= 0) model_dout = rdata;
      else begin model_dout = 16'hDEAD; model_err = 1'b1; end
    end
    check("ack_latency", cyc, exp_cyc);
    check("ack_match", mem_req_ack, mem_req);
    check("cmd_count", n_cmd, is_cmd ? 1 : 0);
    check("valid_after_accept", late_valid, 0);
    if (is_cmd && rdy_dly > 0) check("cmd_stable", stable, 1);
    check("dout", mem_dout, model_dout);
    check("err", err, model_err);
    prev_ds0 = !is_cmd;
  endtask

  task automatic check_reset_outputs(input string tag);
    check(tag, {mem_req_ack, mem_dout, sd_cmd_valid, sd_we, sd_addr, sd_ds, sd_wdata, err}, 64'd0);
  endtask

  initial begin
    bit seen_cmd;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    resetn = 1'b1;

    run_txn(0, 1'b0, 22'h12345, 2'b11, 16'h1111, 0, 3, 16'hBEEF);
    run_txn(0, 1'b1, 22'h00ABC, 2'b10, 16'hA55A, 5, 0, 16'h0000);
    run_txn(0, 1'b1, 22'h3FFFF, 2'b00, 16'h7777, 0, 0, 16'h0000);
    run_txn(0, 1'b0, 22'h00001, 2'b01, 16'h0000, 1, 2, 16'h1234);
    run_txn(1, 1'b0, 22'h3FFFFF, 2'b11, 16'h0000, 0, 0, 16'h5678);
    run_txn(1, 1'b1, 22'h2AAAA, 2'b00, 16'h0F0F, 0, 0, 16'h0000);
    run_txn(1, 1'b0, 22'h15555, 2'b10, 16'h0000, 2, 1, 16'hC3C3);

    for (int i = 0; i < 40; i++) begin
      run_txn(1'($urandom), 1'($urandom), 22'($urandom), 2'($urandom), 16'($urandom),
              $urandom_range(0, 4), $urandom_range(0, 5), 16'($urandom));
    end

`ifdef SDRAM_RESP_TIMEOUT_EN
    run_txn(0, 1'b0, 22'h0BEEF, 2'b11, 16'h0000, 1, -1, 16'h0000);
    run_txn(0, 1'b0, 22'h00042, 2'b11, 16'h0000, 0, 2, 16'h600D);
`endif

    // Reset while a read waits for its data.
    @(negedge clk);
    mem_we = 1'b0; mem_addr = 22'h12345; mem_ds = 2'b11;
    mem_req = ~mem_req;
    @(negedge clk);
    sd_cmd_ready = 1'b1;
    @(negedge clk);
    sd_cmd_ready = 1'b0;
    @(negedge clk);
    #2 resetn = 1'b0;
    mem_req = 1'b0;
    #1 check_reset_outputs("async_reset");
    model_dout = 16'h0000;
    model_err = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    seen_cmd = 0;
    repeat (6) begin
      @(negedge clk);
      if (sd_cmd_valid) seen_cmd = 1;
    end
    check("post_reset_no_cmd", seen_cmd, 0);
    check("post_reset_ack", mem_req_ack, 0);
    check("post_reset_dout", mem_dout, model_dout);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
